// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg: shared types and control encodings for the pipeline sequencer
package pipeline_controller_pkg;
  typedef logic [4:0] regbits_t;
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} ctrl_state_t;
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;
  localparam ctrl_t C_NONE    = 7'b0000000;
  localparam ctrl_t C_RUN     = 7'b1111100;
  localparam ctrl_t C_CLEAR   = 7'b1111111;
  localparam ctrl_t C_HALT    = 7'b0000100;
  localparam ctrl_t C_LOADUSE = 7'b0011101;
  localparam ctrl_t C_FMISS   = 7'b0111110;
endpackage

// File: rtl/pipeline_controller_if.sv
// pipeline_controller_if: hazard inputs and latch controls between datapath and sequencer
interface pipeline_controller_if import pipeline_controller_pkg::*; #(parameter int CNT_W = 16);
  logic ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, ifid_uses_rt, ex_redirect, memwb_halt;
  regbits_t idex_wsel, ifid_rs, ifid_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    input ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_wsel, ifid_rs, ifid_rt,
          ifid_uses_rt, ex_redirect, memwb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt,
           stall_cnt, flush_cnt
  );
  modport slave (
    output ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_wsel, ifid_rs, ifid_rt,
           ifid_uses_rt, ex_redirect, memwb_halt,
    input pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt,
          stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_controller_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 16) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  // count up on inc, hold once saturated
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else if (inc && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush sequencer deciding advance, hold or bubble for each pipeline latch
module pipeline_controller import pipeline_controller_pkg::*; #(parameter int CNT_W = 16) (
  input logic CLK,
  input logic RST,
  pipeline_controller_if.master bus
);
  ctrl_state_t state_q, state_d;
  logic halt_q;
  ctrl_t ctrl;
  logic mem_acc, load_use, freeze, active, redirect_fire, stall_inc;
  assign mem_acc  = bus.exmem_dREN | bus.exmem_dWEN;
  assign load_use = bus.idex_dREN && bus.idex_wsel != '0 &&
                    (bus.idex_wsel == bus.ifid_rs || (bus.ifid_uses_rt && bus.idex_wsel == bus.ifid_rt));
  // in DWAIT only dhit matters; in RUN a pending halt outranks a new miss
  assign freeze   = state_q == DWAIT ? !bus.dhit : (mem_acc && !bus.dhit && !bus.memwb_halt);
  assign active   = !RST && state_q != HALTED && !freeze;
  assign redirect_fire = active && !bus.memwb_halt && bus.ex_redirect;
  assign stall_inc = !RST && state_q != HALTED && !ctrl.pc_en;
  // priority decoder: reset, halted, freeze, halt, redirect, load-use, fetch miss, run
  always_comb begin
    ctrl = RST ? C_CLEAR :
           (state_q == HALTED || freeze) ? C_NONE :
           bus.memwb_halt ? C_HALT :
           bus.ex_redirect ? C_CLEAR :
           load_use ? C_LOADUSE :
           !bus.ihit ? C_FMISS : C_RUN;
    state_d = RST ? RUN :
              state_q == HALTED ? HALTED :
              freeze ? DWAIT :
              bus.memwb_halt ? HALTED : RUN;
  end
  // state register with registered halt flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= state_d == HALTED;
    end
  end
  assign {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en, bus.ifid_flush, bus.idex_flush} = ctrl;
  assign bus.halt = halt_q;
  sat_counter #(.W(CNT_W)) u_stall (.CLK(CLK), .RST(RST), .inc(stall_inc), .cnt(bus.stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush (.CLK(CLK), .RST(RST), .inc(redirect_fire), .cnt(bus.flush_cnt));
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed stimulus checked against a rule-level model of the sequencer
module tb_pipeline_controller;
  localparam int W = 4;
  localparam int SAT = 15;
  logic clk, rst;
  int n_pass, n_tot;
  pipeline_controller_if #(.CNT_W(W)) bus();
  pipeline_controller #(.CNT_W(W)) dut (.CLK(clk), .RST(rst), .bus(bus.master));

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // model: which rule of the spec applies this cycle, then its enable pattern
  logic m_known = 1'b0, m_halted = 1'b0, m_wait = 1'b0;
  int m_stall = 0, m_flush = 0;
  logic x_known = 1'b0, x_halted = 1'b0, x_wait = 1'b0;
  int x_stall = 0, x_flush = 0;
  // bits: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush
  logic [6:0] tab [8] = '{7'b1111111, 7'b0000000, 7'b0000000, 7'b0000100,
                          7'b1111111, 7'b0011101, 7'b0111110, 7'b1111100};

  function automatic int rule();
    logic acc, lu;
    acc = bus.exmem_dREN | bus.exmem_dWEN;
    lu = bus.idex_dREN && bus.idex_wsel != 0 &&
         (bus.idex_wsel == bus.ifid_rs || (bus.ifid_uses_rt && bus.idex_wsel == bus.ifid_rt));
    if (rst) return 0;
    if (m_halted) return 1;
    if (m_wait && !bus.dhit) return 2;
    if (bus.memwb_halt) return 3;
    if (!m_wait && acc && !bus.dhit) return 2;
    if (bus.ex_redirect) return 4;
    if (lu) return 5;
    if (!bus.ihit) return 6;
    return 7;
  endfunction

  always @(negedge clk) begin
    int r;
    r = rule();
    chk("ctrl", int'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                      bus.ifid_flush, bus.idex_flush}), int'(tab[r]));
    if (m_known) begin
      chk("halt", int'(bus.halt), int'(m_halted));
      chk("stall_cnt", int'(bus.stall_cnt), m_stall);
      chk("flush_cnt", int'(bus.flush_cnt), m_flush);
    end
    x_known = 1'b1; x_halted = m_halted; x_wait = m_wait; x_stall = m_stall; x_flush = m_flush;
    if (!m_known && r != 0) x_known = 1'b0;
    case (r)
      0: begin x_halted = 0; x_wait = 0; x_stall = 0; x_flush = 0; end
      1: ;
      2: begin x_wait = 1; x_stall = m_stall + 1; end
      3: begin x_halted = 1; x_wait = 0; x_stall = m_stall + 1; end
      4: begin x_wait = 0; x_flush = m_flush + 1; end
      5, 6: begin x_wait = 0; x_stall = m_stall + 1; end
      default: x_wait = 0;
    endcase
    if (x_stall > SAT) x_stall = SAT;
    if (x_flush > SAT) x_flush = SAT;
  end

  always @(posedge clk) begin
    m_known <= x_known; m_halted <= x_halted; m_wait <= x_wait;
    m_stall <= x_stall; m_flush <= x_flush;
  end

  task automatic idle();
    bus.ihit = 1; bus.dhit = 0; bus.exmem_dREN = 0; bus.exmem_dWEN = 0; bus.idex_dREN = 0;
    bus.idex_wsel = 0; bus.ifid_rs = 1; bus.ifid_rt = 2; bus.ifid_uses_rt = 0;
    bus.ex_redirect = 0; bus.memwb_halt = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; idle(); cyc(); rst = 0;
  endtask

  initial begin
    n_pass = 0; n_tot = 0;
    rst = 1; idle();
    #1;
    chk("rst_pc_en", int'(bus.pc_en), 1);
    chk("rst_flushes", int'({bus.ifid_flush, bus.idex_flush}), 3);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("post_rst_halt", int'(bus.halt), 0);
    chk("post_rst_stall", int'(bus.stall_cnt), 0);
    chk("post_rst_flush", int'(bus.flush_cnt), 0);
    // load-use
    cyc();
    bus.idex_dREN = 1; bus.idex_wsel = 5; bus.ifid_rs = 5;
    #1;
    chk("lu_pc_en", int'(bus.pc_en), 0);
    chk("lu_ifid_en", int'(bus.ifid_en), 0);
    chk("lu_idex_flush", int'(bus.idex_flush), 1);
    cyc();
    bus.idex_wsel = 0;
    #1;
    chk("lu_stall_cnt", int'(bus.stall_cnt), 1);
    chk("lu_wsel0_pc_en", int'(bus.pc_en), 1);
    // data miss
    cyc(); do_reset();
    bus.exmem_dREN = 1; bus.dhit = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dmiss_frozen", int'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}), 0);
      cyc();
    end
    bus.dhit = 1;
    #1;
    chk("dhit_release", int'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}), 31);
    chk("dmiss_stall_cnt", int'(bus.stall_cnt), 3);
    cyc(); idle();
    // redirect with fetch miss
    bus.ex_redirect = 1; bus.ihit = 0;
    #1;
    chk("redir_pc_en", int'(bus.pc_en), 1);
    chk("redir_flushes", int'({bus.ifid_flush, bus.idex_flush}), 3);
    cyc(); idle();
    #1;
    chk("redir_flush_cnt", int'(bus.flush_cnt), 1);
    // data miss together with redirect: freeze first, redirect after dhit
    bus.exmem_dREN = 1; bus.ex_redirect = 1;
    #1;
    chk("miss_redir_pc_en", int'(bus.pc_en), 0);
    cyc();
    bus.dhit = 1;
    #1;
    chk("miss_redir_release", int'(bus.idex_flush), 1);
    cyc(); idle();
    #1;
    chk("miss_redir_flush_cnt", int'(bus.flush_cnt), 2);
    // load-use with fetch miss
    bus.idex_dREN = 1; bus.idex_wsel = 7; bus.ifid_rt = 7; bus.ifid_uses_rt = 1; bus.ihit = 0;
    #1;
    chk("lu_fmiss_ifid", int'({bus.ifid_en, bus.ifid_flush, bus.idex_flush}), 1);
    cyc(); idle();
    // halt
    bus.memwb_halt = 1;
    #1;
    chk("halt_enables", int'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}), 1);
    cyc();
    #1;
    chk("halt_rises", int'(bus.halt), 1);
    for (int i = 0; i < 10; i++) begin
      bus.memwb_halt = 1'($urandom); bus.ex_redirect = 1'($urandom); bus.ihit = 1'($urandom);
      bus.exmem_dREN = 1'($urandom); bus.idex_dREN = 1'($urandom); bus.idex_wsel = 5'($urandom);
      #1;
      chk("halted_enables", int'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}), 0);
      chk("halted_stall_cnt", int'(bus.stall_cnt), 6);
      chk("halted_flush_cnt", int'(bus.flush_cnt), 2);
      cyc();
    end
    idle(); rst = 1;
    #1;
    chk("halted_rst_clear", int'(bus.pc_en), 1);
    cyc(); rst = 0;
    #1;
    chk("rst_leaves_halt", int'(bus.halt), 0);
    chk("rst_leaves_pc_en", int'(bus.pc_en), 1);
    // halt arriving with dhit in DWAIT
    bus.exmem_dREN = 1;
    cyc();
    bus.dhit = 1; bus.memwb_halt = 1;
    #1;
    chk("dwait_halt_memwb", int'({bus.pc_en, bus.memwb_en}), 1);
    cyc(); idle();
    #1;
    chk("dwait_halt_rises", int'(bus.halt), 1);
    // saturation
    do_reset();
    bus.idex_dREN = 1; bus.idex_wsel = 9; bus.ifid_rs = 9;
    repeat (20) cyc();
    chk("stall_saturates", int'(bus.stall_cnt), SAT);
    idle();
    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the five-stage pipeline.
- Decides each cycle whether the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches advance, hold or load a bubble.
- Covers cache-miss waits, load-use hazards (the one case the forwarding unit cannot resolve), taken branches/jumps, and halt.
- Keeps saturating stall and flush counters for performance reporting.

## Interface
Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt counters.

Ports:
- CLK  in  1  system clock; one clock domain.
- RST  in  1  reset; reset is synchronous and active-high.
- ihit  in  1  instruction cache returned a valid instruction this cycle.
- dhit  in  1  data cache completed the access this cycle.
- exmem_dREN, exmem_dWEN  in  1 each  the instruction in MEM reads or writes memory.
- idex_dREN  in  1  the instruction in EX is a load.
- idex_wsel  in  5  destination register of the instruction in EX.
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in decode.
- ifid_uses_rt  in  1  the decode instruction reads rt as a source.
- ex_redirect  in  1  EX resolved a taken branch or a jump.
- memwb_halt  in  1  a HALT instruction is in WB.
- pc_en  out  1  PC register loads its next value.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch write enables.
- ifid_flush, idex_flush  out  1 each  when the latch is enabled, it loads a NOP bubble instead of its input.
- halt  out  1  registered; processor halted.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

## Operation
FSM states: RUN, DWAIT, HALTED.
- RST asserted, which overrides everything:
  - next state RUN; halt, stall_cnt and flush_cnt become 0.
  - During the RST cycle all enables are 1 and both flushes are 1, so the pipeline clears.

Per-cycle decision in RUN. The first matching rule wins.
1. **Halt:** memwb_halt=1.
   - memwb_en=1 so the halt retires; all other enables are 0.
   - Next state is HALTED.
2. **Data miss:** (exmem_dREN|exmem_dWEN)=1 and dhit=0.
   - All enables and pc_en are 0.
   - Next state is DWAIT.
3. **Redirect:** ex_redirect=1.
   - pc_en=1, all latch enables 1, ifid_flush=1, idex_flush=1.
   - This applies even when ihit=0; the in-flight fetch is abandoned.
4. **Load-use:** idex_dREN=1, idex_wsel≠0, and (idex_wsel==ifid_rs, or ifid_uses_rt with idex_wsel==ifid_rt).
   - pc_en=0 and ifid_en=0.
   - idex_en=1 with idex_flush=1; exmem_en=1 and memwb_en=1.
5. **Fetch miss:** ihit=0.
   - pc_en=0; all latches enabled; ifid_flush=1.
6. **Otherwise:** all enables 1, no flushes.

DWAIT:
- dhit=0: all enables and pc_en are 0; stay in DWAIT.
- dhit=1: the rules above are applied with the data-miss rule treated as satisfied, so the freeze is released. Next state is RUN, or HALTED if the halt rule fired.

HALTED:
- All enables and flushes are 0, and halt=1.
- The state is left only through RST.

Counters:
- stall_cnt increments on every cycle in RUN or DWAIT where pc_en=0.
- flush_cnt increments on every cycle where the redirect rule fires.
- Both saturate at 2^CNT_W−1 and never wrap.
- Both are frozen in HALTED.

## Timing
- Enables and flushes are combinational from the inputs and the current state. They take effect at the next CLK edge.
- halt rises on the edge after memwb_halt is first seen in RUN (or in DWAIT with dhit=1).
- A load-use hazard costs exactly 1 bubble. In the following cycle the load is in MEM, and the forwarding unit supplies the result from the MEM/WB side.
- A redirect costs 2 bubbles (IF/ID and ID/EX) and is counted once in flush_cnt.
- Simultaneous data miss and redirect: the freeze wins. The redirect is re-evaluated once dhit arrives, because EX is held and ex_redirect stays asserted.
- Simultaneous load-use and fetch miss: the load-use rule applies. ifid_en=0 preserves the decode instruction; the stall counts once.
- RST in DWAIT or HALTED: state returns to RUN on the next edge; any pending miss is abandoned.

## Structure
- Add to cpu_types_pkg:
  - the ctrl_state_t enum {RUN, DWAIT, HALTED};
  - the existing regbits_t, used for the wsel/rs/rt ports.
- One sub-module, sat_counter (parameter W, ports CLK, RST, inc, cnt), instantiated twice.
- The FSM and the priority decoder stay in pipeline_controller.

## Test plan
- **Reset:** hold RST for 2 cycles. During RST, all enables and both flushes are 1. After release, halt=0 and stall_cnt=flush_cnt=0.
- **Load-use:** idex_dREN=1, idex_wsel=5, ifid_rs=5, ihit=1.
  - Expect pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle; stall_cnt becomes 1.
  - With idex_wsel=0 there is no stall.
- **Data miss:** exmem_dREN=1 with dhit low for 3 cycles.
  - State is DWAIT and all enables are 0 for those 3 cycles.
  - On the dhit=1 cycle all enables are 1; stall_cnt=3.
- **Redirect with fetch miss:** ex_redirect=1, ihit=0.
  - Expect pc_en=1, ifid_flush=idex_flush=1; flush_cnt+1.
- **Halt:** memwb_halt=1.
  - Only memwb_en=1 that cycle; halt=1 on the next edge.
  - The state then stays HALTED for 10 cycles with all enables 0 and counters frozen.
  - RST returns it to RUN.
- **Saturation:** with CNT_W=4, stall for 20 cycles; stall_cnt holds at 15.
